// File: rtl/irq_pkg.sv
// Shared state type and default sizing for the interrupt controller.
package irq_pkg;

  localparam int NUM_IRQ_DEFAULT = 4;
  localparam int ID_W_DEFAULT    = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

endpackage

// File: rtl/irq_arbiter.sv
// Combinational winner selection over the eligible interrupt sources.
// IRQ_ROUND_ROBIN_EN selects round-robin from rr_ptr_i; otherwise the lowest index wins.
module irq_arbiter #(
  parameter int NUM_IRQ = 4,
  parameter int ID_W    = 4
) (
  input  logic [NUM_IRQ-1:0] eligible_i,
  input  logic [ID_W-1:0]    rr_ptr_i,
  output logic [ID_W-1:0]    winner_o,
  output logic               valid_o
);

`ifdef IRQ_ROUND_ROBIN_EN
  // The eligible source closest to rr_ptr_i, counting upward with wrap, wins.
  always_comb begin
    int best_dist;
    int dist;
    best_dist = NUM_IRQ;
    dist      = 0;
    winner_o  = '0;
    valid_o   = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      dist = (i + NUM_IRQ - int'(rr_ptr_i)) % NUM_IRQ;
      if (eligible_i[i] && (dist < best_dist)) begin
        best_dist = dist;
        winner_o  = ID_W'(i);
        valid_o   = 1'b1;
      end else begin
      end
    end
  end
`else
  logic unused_rr_s;
  assign unused_rr_s = ^rr_ptr_i;

  // Downward scan: the lowest eligible index is the last one written.
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible_i[i]) begin
        winner_o = ID_W'(i);
        valid_o  = 1'b1;
      end else begin
      end
    end
  end
`endif

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: edge capture, pending/mask, single ExtIRQ handshake with ack pulses.
// Arbitration mode is chosen by IRQ_ROUND_ROBIN_EN inside irq_arbiter; ports and FSM are identical.
module irq_controller #(
  parameter int NUM_IRQ = irq_pkg::NUM_IRQ_DEFAULT,
  parameter int ID_W    = irq_pkg::ID_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic [NUM_IRQ-1:0] irq_mask,
  output logic               ExtIRQ,
  input  logic               ExtIAck,
  input  logic               ERet,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic [ID_W-1:0]    irq_id,
  output logic               busy
);
  import irq_pkg::*;

  irq_state_t         state_q, state_d;
  logic [NUM_IRQ-1:0] req_prev_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] ack_q, ack_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic               ext_irq_q;
  logic               busy_q;
  logic [NUM_IRQ-1:0] edge_s;
  logic [NUM_IRQ-1:0] eligible_s;
  logic [ID_W-1:0]    win_id_s;
  logic               win_valid_s;

  assign edge_s     = irq_req & ~req_prev_q;
  assign eligible_s = pending_q & irq_mask;

  irq_arbiter #(
    .NUM_IRQ (NUM_IRQ),
    .ID_W    (ID_W)
  ) u_arbiter (
    .eligible_i (eligible_s),
    .rr_ptr_i   (rr_ptr_q),
    .winner_o   (win_id_s),
    .valid_o    (win_valid_s)
  );

  // Handshake FSM plus pending update; a fresh edge beats the ack clear.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;
    ack_d    = '0;
    case (state_q)
      IDLE: begin
        if (win_valid_s) begin
          state_d = REQ;
          id_d    = win_id_s;
        end else begin
        end
      end
      REQ: begin
        if (ExtIAck) begin
          state_d  = SERVICE;
          ack_d    = NUM_IRQ'(1) << id_q;
          rr_ptr_d = (id_q == ID_W'(NUM_IRQ - 1)) ? '0 : id_q + ID_W'(1);
        end else begin
        end
      end
      SERVICE: begin
        if (ERet) begin
          state_d = IDLE;
        end else begin
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    pending_d = (pending_q & ~ack_d) | edge_s;
  end

  // Lines already high during reset are not treated as new edges afterwards.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      req_prev_q <= irq_req;
      pending_q  <= '0;
      ack_q      <= '0;
      id_q       <= '0;
      rr_ptr_q   <= '0;
      ext_irq_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_prev_q <= irq_req;
      pending_q  <= pending_d;
      ack_q      <= ack_d;
      id_q       <= id_d;
      rr_ptr_q   <= rr_ptr_d;
      ext_irq_q  <= (state_d == REQ);
      busy_q     <= (state_d != IDLE);
    end
  end

  assign ExtIRQ  = ext_irq_q;
  assign irq_ack = ack_q;
  assign irq_id  = id_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed, table-driven bench for irq_controller (4 sources); the round-robin
// sequence runs only when IRQ_ROUND_ROBIN_EN is defined.
module tb_irq_controller;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] mask;
    logic       iack;
    logic       eret;
    logic       rst;
    logic       irq;
    logic [3:0] ack;
    logic [3:0] id;
    logic       bsy;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] irq_req = 4'd0;
  logic [3:0] irq_mask = 4'hF;
  logic       ExtIAck = 1'b0;
  logic       ERet = 1'b0;
  logic       ExtIRQ;
  logic [3:0] irq_ack;
  logic [3:0] irq_id;
  logic       busy;

  int pass_cnt = 0;
  int total_cnt = 0;
  vec_t vecs[$];

  irq_controller #(.NUM_IRQ(4), .ID_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .irq_req  (irq_req),
    .irq_mask (irq_mask),
    .ExtIRQ   (ExtIRQ),
    .ExtIAck  (ExtIAck),
    .ERet     (ERet),
    .irq_ack  (irq_ack),
    .irq_id   (irq_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // exp_id < 0 means the ID is not checked
  task automatic check(input string name, input logic e_irq, input logic [3:0] e_ack,
                       input int e_id, input logic e_bsy);
    total_cnt++;
    if (ExtIRQ === e_irq && irq_ack === e_ack && busy === e_bsy &&
        (e_id < 0 || irq_id === 4'(e_id))) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got irq=%b ack=%b id=%0d busy=%b, want irq=%b ack=%b id=%0d busy=%b",
               name, ExtIRQ, irq_ack, irq_id, busy, e_irq, e_ack, e_id, e_bsy);
    end
  endtask

  task automatic add(input logic [3:0] rq, input logic [3:0] mk, input logic ia, input logic er,
                     input logic rs, input logic ei, input logic [3:0] ea, input logic [3:0] eid,
                     input logic eb);
    vecs.push_back('{rq, mk, ia, er, rs, ei, ea, eid, eb});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //  req    mask   ia    er    rst   irq   ack    id     busy
    add(4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'd0, 1'b0);  // reset state
    add(4'h0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'd0, 1'b0);
`ifndef IRQ_ROUND_ROBIN_EN
    // single IRQ on source 2
    add(4'h4, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'd0, 1'b0);
    add(4'h4, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'd2, 1'b1);
    add(4'h4, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 4'h4, 4'd2, 1'b1);
    add(4'h4, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'd2, 1'b1);
    add(4'h4, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'd2, 1'b0);
    add(4'h0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'd2, 1'b0);
    // simultaneous 1 and 3, fixed priority
    add(4'hA, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'd2, 1'b0);
    add(4'hA, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'd1, 1'b1);
    add(4'hA, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 4'h2, 4'd1, 1'b1);
    add(4'hA, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'd1, 1'b1);
    add(4'hA, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'd1, 1'b0);
    add(4'hA, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'd3, 1'b1);
    add(4'hA, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 4'h8, 4'd3, 1'b1);
    add(4'hA, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'd3, 1'b0);
    add(4'h0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'd3, 1'b0);
    // handshake guards
    add(4'h0, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'd3, 1'b0);
    add(4'h0, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'd3, 1'b0);
    add(4'h1, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'd3, 1'b0);
    add(4'h1, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'd0, 1'b1);
    add(4'h1, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 4'd0, 1'b1);
    add(4'h1, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 4'h1, 4'd0, 1'b1);
    add(4'h3, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'd0, 1'b1);
    add(4'h3, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'd0, 1'b1);
    add(4'h3, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'd0, 1'b0);
    add(4'h3, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'd1, 1'b1);
    add(4'h3, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 4'h2, 4'd1, 1'b1);
    add(4'h3, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'd1, 1'b0);
    add(4'h0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'd1, 1'b0);
    // mask removed while in REQ: request stays committed
    add(4'h4, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'd1, 1'b0);
    add(4'h4, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'd2, 1'b1);
    add(4'h4, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'd2, 1'b1);
    add(4'h4, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h4, 4'd2, 1'b1);
    add(4'h4, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'd2, 1'b0);
    add(4'h0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'd2, 1'b0);
    // new edge in the ack cycle keeps pending set
    add(4'h2, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'd2, 1'b0);
    add(4'h2, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'd1, 1'b1);
    add(4'h0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'd1, 1'b1);
    add(4'h2, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 4'h2, 4'd1, 1'b1);
    add(4'h2, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'd1, 1'b0);
    add(4'h2, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'd1, 1'b1);
    add(4'h2, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 4'h2, 4'd1, 1'b1);
    add(4'h0, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'd1, 1'b0);
    add(4'h0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'd1, 1'b0);
`endif

    for (int v = 0; v < vecs.size(); v++) begin
      irq_req  = vecs[v].req;
      irq_mask = vecs[v].mask;
      ExtIAck  = vecs[v].iack;
      ERet     = vecs[v].eret;
      reset    = vecs[v].rst;
      tick();
      check($sformatf("vec%0d", v), vecs[v].irq, vecs[v].ack, int'(vecs[v].id), vecs[v].bsy);
    end
    ExtIAck = 1'b0;
    ERet    = 1'b0;

    // masked source keeps its pending bit until enabled
    irq_req = 4'h0; irq_mask = 4'hE;
    tick();
    irq_req = 4'h1;
    tick();
    for (int c = 0; c < 10; c++) begin
      tick();
      check("mask_hold", 1'b0, 4'h0, -1, 1'b0);
    end
    irq_mask = 4'hF;
    tick();
    check("mask_release", 1'b1, 4'h0, 0, 1'b1);
    ExtIAck = 1'b1;
    tick();
    check("mask_ack", 1'b0, 4'h1, 0, 1'b1);
    ExtIAck = 1'b0; ERet = 1'b1;
    tick();
    check("mask_eret", 1'b0, 4'h0, 0, 1'b0);
    ERet = 1'b0; irq_req = 4'h0;
    tick();

    // reset during SERVICE with source 3 still pending
    irq_req = 4'h4;
    tick();
    tick();
    check("rst_req", 1'b1, 4'h0, 2, 1'b1);
    irq_req = 4'hC; ExtIAck = 1'b1;
    tick();
    check("rst_ack", 1'b0, 4'h4, 2, 1'b1);
    ExtIAck = 1'b0; reset = 1'b0;
    tick();
    check("rst_apply", 1'b0, 4'h0, 0, 1'b0);
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("rst_after", 1'b0, 4'h0, 0, 1'b0);
    end
    irq_req = 4'h0;
    tick();
    irq_req = 4'h8;
    tick();
    tick();
    check("rst_recover", 1'b1, 4'h0, 3, 1'b1);
    ExtIAck = 1'b1;
    tick();
    ExtIAck = 1'b0; ERet = 1'b1;
    tick();
    ERet = 1'b0; irq_req = 4'h0;
    tick();

`ifdef IRQ_ROUND_ROBIN_EN
    // sources 0 and 1 re-request after each service; IDs must alternate
    irq_req = 4'h0;
    tick();
    irq_req = 4'h3;
    for (int r = 0; r < 6; r++) begin
      for (int n = 0; n < 10 && !ExtIRQ; n++) tick();
      check("rr_order", 1'b1, 4'h0, r % 2, 1'b1);
      ExtIAck = 1'b1;
      irq_req = 4'h3 & ~(4'h1 << (r % 2));
      tick();
      ExtIAck = 1'b0; ERet = 1'b1;
      irq_req = 4'h3;
      tick();
      ERet = 1'b0;
    end
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
